// File: rtl/mem_responder.sv
// Word RAM responder for the datapath memory interface: accepts one read or write
// at a time, inserts wait states, and pulses mem_done when the access completes.
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] mdatain,
  output logic              mem_done,
  output logic              busy
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                op_write;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   ram [DEPTH];
  logic                commit;

  // The access happens on the edge that leaves WAIT, so the request sampled at
  // edge k completes at edge k+WAIT_CYCLES+1 for every WAIT_CYCLES, including 0.
  assign commit = (state == WAIT) && (cnt == '0);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      mdatain  <= '0;
      mem_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      unique case (state)
        IDLE: begin
          // Write wins when both strobes are high; the read is dropped.
          if (mem_read || mem_write) begin
            state    <= WAIT;
            cnt      <= WAIT_CNT;
            op_write <= mem_write;
            addr_q   <= address;
            data_q   <= data_in;
            busy     <= 1'b1;
          end
        end
        WAIT: begin
          if (commit) begin
            state    <= RESP;
            mem_done <= 1'b1;
            if (!op_write) begin
              mdatain <= ram[addr_q];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the RAM array has no reset; its contents survive reset and it maps onto
  // block memory. An aborted write never commits because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (commit && op_write) begin
      ram[addr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance
// checked every cycle against a transaction-level model, plus directed scenarios.
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int DW  = 32;
  localparam int AW  = 9;
  localparam int WC0 = 2;
  localparam int WC1 = 0;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0]         rd = '0;
  logic [1:0]         wr = '0;
  logic [1:0][AW-1:0] addr = '0;
  logic [1:0][DW-1:0] din = '0;
  logic [1:0][DW-1:0] mdat;
  logic [1:0]         done;
  logic [1:0]         busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC0)) dut0 (
    .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]),
    .address(addr[0]), .data_in(din[0]), .mdatain(mdat[0]),
    .mem_done(done[0]), .busy(busy[0])
  );

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC1)) dut1 (
    .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]),
    .address(addr[1]), .data_in(din[1]), .mdatain(mdat[1]),
    .mem_done(done[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wc(input int i);
    return (i == 0) ? WC0 : WC1;
  endfunction

  // Transaction-level model: a request accepted at edge k completes at edge
  // k+W+1 (done and RAM access), and the responder is idle again at edge k+W+2.
  logic [DW-1:0] m_ram   [2][DEPTH];
  bit            m_known [2][DEPTH];
  bit            m_act   [2];
  longint        m_acc   [2];
  bit            m_wr    [2];
  logic [AW-1:0] m_a     [2];
  logic [DW-1:0] m_d     [2];
  logic [DW-1:0] m_rdata [2] = '{default: '0};
  bit            m_rknown[2] = '{default: 1'b1};
  bit            m_done  [2];
  bit            m_busy  [2];
  longint        edge_n = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i]    = 1'b0;
        m_rdata[i]  = '0;
        m_rknown[i] = 1'b1;
        m_done[i]   = 1'b0;
        m_busy[i]   = 1'b0;
      end
    end else begin
      edge_n++;
      for (int i = 0; i < 2; i++) begin
        if (!m_act[i]) begin
          if (rd[i] || wr[i]) begin
            m_act[i] = 1'b1;
            m_acc[i] = edge_n;
            m_wr[i]  = wr[i];
            m_a[i]   = addr[i];
            m_d[i]   = din[i];
          end
        end else if (edge_n == m_acc[i] + wc(i) + 1) begin
          if (m_wr[i]) begin
            m_ram[i][m_a[i]]   = m_d[i];
            m_known[i][m_a[i]] = 1'b1;
          end else begin
            m_rdata[i]  = m_ram[i][m_a[i]];
            m_rknown[i] = m_known[i][m_a[i]];
          end
        end else if (edge_n == m_acc[i] + wc(i) + 2) begin
          m_act[i] = 1'b0;
        end
        m_busy[i] = m_act[i];
        m_done[i] = m_act[i] && (edge_n == m_acc[i] + wc(i) + 1);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("mem_done[%0d]", i), done[i], m_done[i]);
        check($sformatf("busy[%0d]", i), busy[i], m_busy[i]);
        if (m_rknown[i]) check($sformatf("mdatain[%0d]", i), mdat[i], m_rdata[i]);
      end
    end
  end

  // Issue one transaction from a negedge; returns at the negedge of its done cycle
  // with the strobes dropped. Address and data are scrambled after acceptance.
  task automatic txn(input int i, input bit r, input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input int exp_lat, input string name);
    int n;
    bit seen;
    n = 0;
    while (busy[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle"}, busy[i], 1'b0);
    rd[i] = r; wr[i] = w; addr[i] = a; din[i] = d;
    @(posedge clk);
    @(negedge clk);
    addr[i] = AW'($urandom);
    din[i]  = $urandom;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = done[i];
    end
    check({name, " done seen"}, seen, 1'b1);
    check({name, " latency"}, n, exp_lat);
    rd[i] = 1'b0;
    wr[i] = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    logic [31:0] mar;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset mdatain", mdat[0], 32'h0);
    check("reset busy", busy[0], 1'b0);

    // Reset aborts a pending write: addr 5 keeps its old word.
    txn(0, 1'b0, 1'b1, 9'h005, 32'h0, 3, "t1 init");
    n = 0;
    while (busy[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    wr[0] = 1'b1; addr[0] = 9'h005; din[0] = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    wr[0] = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t1 busy in reset", busy[0], 1'b0);
    check("t1 done in reset", done[0], 1'b0);
    check("t1 mdatain in reset", mdat[0], 32'h0);
    @(negedge clk);
    reset = 1'b0;
    txn(0, 1'b1, 1'b0, 9'h005, 32'h0, 3, "t1 read");
    check("t1 read data", mdat[0], 32'h0);

    // Write then read back.
    txn(0, 1'b0, 1'b1, 9'h010, 32'h0000_0022, 3, "t2 write");
    txn(0, 1'b1, 1'b0, 9'h010, 32'h0, 3, "t2 read");
    check("t2 read data", mdat[0], 32'h0000_0022);
    check("t2 model data", m_rdata[0], 32'h0000_0022);

    // Instruction word read; a later write leaves mdatain untouched.
    txn(0, 1'b0, 1'b1, 9'h000, 32'h4A92_0000, 3, "t3 load");
    txn(0, 1'b1, 1'b0, 9'h000, 32'h0, 3, "t3 read");
    check("t3 read data", mdat[0], 32'h4A92_0000);
    txn(0, 1'b0, 1'b1, 9'h040, 32'h0000_1234, 3, "t3 write");
    check("t3 mdatain held", mdat[0], 32'h4A92_0000);

    // Both strobes high: write wins.
    txn(0, 1'b1, 1'b1, 9'h020, 32'h0000_0024, 3, "t4 both");
    check("t4 mdatain held", mdat[0], 32'h4A92_0000);
    txn(0, 1'b1, 1'b0, 9'h020, 32'h0, 3, "t4 read");
    check("t4 read data", mdat[0], 32'h0000_0024);

    // A write strobed while busy is ignored.
    txn(0, 1'b0, 1'b1, 9'h030, 32'h0000_0055, 3, "t5 init");
    n = 0;
    while (busy[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    rd[0] = 1'b1; addr[0] = 9'h040;
    @(posedge clk);
    @(negedge clk);
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 9'h030; din[0] = 32'h0000_0BAD;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done[0]) begin
        pulses++;
        wr[0] = 1'b0;
        check("t5 read data", mdat[0], 32'h0000_1234);
      end
    end
    wr[0] = 1'b0;
    check("t5 pulse count", pulses, 1);
    txn(0, 1'b1, 1'b0, 9'h030, 32'h0, 3, "t5 read");
    check("t5 ram unchanged", mdat[0], 32'h0000_0055);

    // Zero wait states and address wrap on the second instance.
    mar = 32'h0000_01FF;
    txn(1, 1'b0, 1'b1, mar[AW-1:0], 32'hCAFE_F00D, 1, "t6 write");
    mar = 32'h0000_03FF;
    txn(1, 1'b1, 1'b0, mar[AW-1:0], 32'h0, 1, "t6 read");
    check("t6 wrapped read", mdat[1], 32'hCAFE_F00D);
    check("t6 model data", m_rdata[1], 32'hCAFE_F00D);

    // Random traffic on both instances, including back-to-back strobes and resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        rd[i]   = ($urandom_range(0, 99) < 35);
        wr[i]   = ($urandom_range(0, 99) < 30);
        addr[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
        din[i]  = $urandom;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    @(negedge clk);
    rd = '0;
    wr = '0;
    repeat (8) @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
